// File: rtl/vfpu_source_ctrl_pkg.sv
// Shared types and helpers for the vector-FPU source sequencer.
package vfpu_ctrl_package;

    localparam int unsigned VFPU_DATA_WIDTH = 32;
    localparam int unsigned BYTES_PER_WORD  = VFPU_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        ISSUE    = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } vfpu_src_state_t;

    // Size of the next chunk: whatever is left, capped at the burst limit.
    function automatic int unsigned burst_words(input int unsigned remaining,
                                                input int unsigned max_burst);
        int unsigned words;
        if (remaining < max_burst) begin
            words = remaining;
        end else begin
            words = max_burst;
        end
        return words;
    endfunction

endpackage

// File: rtl/vfpu_done_collector.sv
// Sticky per-operand chunk-done tracker with all-done and duplicate-done detection.
module vfpu_done_collector
#(
    parameter int unsigned NB_OPERANDS = 2
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   en,
    input  logic [NB_OPERANDS-1:0] done_in,
    output logic                   all_done,
    output logic                   dup_err
);

    logic [NB_OPERANDS-1:0] seen_r;

    // A done arriving in the same cycle as the last missing one still completes the chunk.
    always_comb begin
        all_done = en && (&(seen_r | done_in));
        dup_err  = en && (|(seen_r & done_in));
    end

    // Accumulate dones while enabled; drop them once the chunk completes.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            seen_r <= '0;
        end else if (all_done) begin
            seen_r <= '0;
        end else if (en) begin
            seen_r <= seen_r | done_in;
        end else begin
            seen_r <= seen_r;
        end
    end

endmodule

// File: rtl/vfpu_source_ctrl.sv
// Splits one vector job into bursts and issues them in lock-step to all operand sources.
module vfpu_source_ctrl
    import vfpu_ctrl_package::*;
#(
    parameter int unsigned NB_OPERANDS = 2,
    parameter int unsigned DATA_WIDTH  = VFPU_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned MAX_BURST   = 16
)
(
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  clear_i,
    input  logic                                  start_i,
    input  logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]                  total_len_i,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  err_o,
    output logic [LEN_WIDTH-1:0]                  chunk_cnt_o,
    output logic [NB_OPERANDS-1:0]                src_req_start_o,
    output logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_base_addr_o,
    output logic [LEN_WIDTH-1:0]                  src_trans_size_o,
    input  logic [NB_OPERANDS-1:0]                src_ready_start_i,
    input  logic [NB_OPERANDS-1:0]                src_done_i
);

    localparam int unsigned STEP = DATA_WIDTH / 8;

    vfpu_src_state_t                       state_r;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] addr_r;
    logic [NB_OPERANDS-1:0][ADDR_WIDTH-1:0] src_addr_r;
    logic [LEN_WIDTH-1:0]                  remaining_r;
    logic [LEN_WIDTH-1:0]                  size_r;
    logic [LEN_WIDTH-1:0]                  chunk_cnt_r;
    logic [NB_OPERANDS-1:0]                req_r;
    logic                                  busy_r;
    logic                                  done_r;
    logic                                  err_r;

    logic                                  run_s;
    logic                                  all_done_s;
    logic                                  dup_err_s;
    logic                                  err_evt_s;
    logic                                  err_next_s;
    logic [ADDR_WIDTH-1:0]                 addr_step_s;

    vfpu_done_collector #(
        .NB_OPERANDS (NB_OPERANDS)
    ) u_done_collector (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (clear_i),
        .en       (run_s),
        .done_in  (src_done_i),
        .all_done (all_done_s),
        .dup_err  (dup_err_s)
    );

    // Protocol error sources; an accepted start wipes the old flag but not a same-cycle event.
    always_comb begin
        run_s       = (state_r == RUN);
        addr_step_s = ADDR_WIDTH'(size_r) * ADDR_WIDTH'(STEP);
        if (run_s) begin
            err_evt_s = dup_err_s;
        end else begin
            err_evt_s = |src_done_i;
        end
        if ((state_r == IDLE) && start_i) begin
            err_next_s = err_evt_s;
        end else begin
            err_next_s = err_r | err_evt_s;
        end
    end

    // Job sequencer; every output is a register written here.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_r     <= IDLE;
            addr_r      <= '0;
            src_addr_r  <= '0;
            remaining_r <= '0;
            size_r      <= '0;
            chunk_cnt_r <= '0;
            req_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            req_r <= '0;
            err_r <= err_next_s;
            case (state_r)
                IDLE: begin
                    if (start_i) begin
                        addr_r      <= base_addr_i;
                        remaining_r <= total_len_i;
                        chunk_cnt_r <= '0;
                        busy_r      <= 1'b1;
                        if (total_len_i == '0) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (&src_ready_start_i) begin
                        state_r    <= ISSUE;
                        req_r      <= '1;
                        src_addr_r <= addr_r;
                        size_r     <= LEN_WIDTH'(burst_words(32'(remaining_r), MAX_BURST));
                    end
                end
                ISSUE: begin
                    state_r <= RUN;
                end
                RUN: begin
                    if (all_done_s) begin
                        remaining_r <= remaining_r - size_r;
                        chunk_cnt_r <= chunk_cnt_r + LEN_WIDTH'(1);
                        for (int i = 0; i < int'(NB_OPERANDS); i++) begin
                            addr_r[i] <= addr_r[i] + addr_step_s;
                        end
                        if (remaining_r == size_r) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= WAIT_RDY;
                        end
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    src_addr_r <= '0;
                    size_r     <= '0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o           = busy_r;
    assign done_o           = done_r;
    assign err_o            = err_r;
    assign chunk_cnt_o      = chunk_cnt_r;
    assign src_req_start_o  = req_r;
    assign src_base_addr_o  = src_addr_r;
    assign src_trans_size_o = size_r;

endmodule

// File: tb/tb_vfpu_source_ctrl.sv
// Scoreboard bench for vfpu_source_ctrl: expected bursts, job completions and point checks are queued.
module tb_vfpu_source_ctrl;

    localparam int NB = 2;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int MB = 16;

    localparam int K_BUSY    = 0;
    localparam int K_DONE    = 1;
    localparam int K_ERR     = 2;
    localparam int K_REQ     = 3;
    localparam int K_ALLZERO = 4;
    localparam int K_QEMPTY  = 5;

    logic                  clk = 1'b0;
    logic                  rst_i, clear_i, start_i;
    logic [NB-1:0][AW-1:0] base_addr_i;
    logic [LW-1:0]         total_len_i;
    logic                  busy_o, done_o, err_o;
    logic [LW-1:0]         chunk_cnt_o;
    logic [NB-1:0]         src_req_start_o;
    logic [NB-1:0][AW-1:0] src_base_addr_o;
    logic [LW-1:0]         src_trans_size_o;
    logic [NB-1:0]         src_ready_start_i;
    logic [NB-1:0]         src_done_i;

    vfpu_source_ctrl #(
        .NB_OPERANDS (NB), .DATA_WIDTH (32), .ADDR_WIDTH (AW),
        .LEN_WIDTH (LW), .MAX_BURST (MB)
    ) dut (
        .clk_i (clk), .rst_i (rst_i), .clear_i (clear_i), .start_i (start_i),
        .base_addr_i (base_addr_i), .total_len_i (total_len_i),
        .busy_o (busy_o), .done_o (done_o), .err_o (err_o), .chunk_cnt_o (chunk_cnt_o),
        .src_req_start_o (src_req_start_o), .src_base_addr_o (src_base_addr_o),
        .src_trans_size_o (src_trans_size_o), .src_ready_start_i (src_ready_start_i),
        .src_done_i (src_done_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] a0; logic [AW-1:0] a1; logic [LW-1:0] size; } issue_t;
    typedef struct { int cnt; bit chk_lat; } job_t;
    typedef struct { int cyc; int kind; logic [31:0] val; string name; } pc_t;

    issue_t issue_q[$];
    job_t   done_q[$];
    pc_t    pc_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    // Source model knobs
    int dly0 = 3, dly1 = 3;
    int ready_low_until = 0;
    int inject_cyc = -1;
    int last_done_cyc = -100;

    function automatic void push_pc(input int c, input int k, input logic [31:0] v, input string n);
        pc_t p;
        int  i;
        p.cyc = c; p.kind = k; p.val = v; p.name = n;
        i = 0;
        while (i < pc_q.size() && pc_q[i].cyc <= c) i++;
        pc_q.insert(i, p);
    endfunction

    function automatic logic [31:0] probe(input int kind);
        case (kind)
            K_BUSY:    return 32'(busy_o);
            K_DONE:    return 32'(done_o);
            K_ERR:     return 32'(err_o);
            K_REQ:     return 32'(src_req_start_o);
            K_ALLZERO: return 32'(busy_o || done_o || err_o || chunk_cnt_o != '0 ||
                                  src_req_start_o != '0 || src_base_addr_o != '0 ||
                                  src_trans_size_o != '0);
            K_QEMPTY:  return 32'(issue_q.size() + done_q.size());
            default:   return 32'hdead_beef;
        endcase
    endfunction

    // Behavioural sources: accept bursts, report done after a per-operand delay.
    initial begin : responder
        int cnt [NB];
        src_done_i = '0;
        src_ready_start_i = '1;
        for (int i = 0; i < NB; i++) cnt[i] = 0;
        forever begin
            @(posedge clk); #1;
            src_done_i = '0;
            if (!busy_o) begin
                for (int i = 0; i < NB; i++) cnt[i] = 0;
            end else begin
                for (int i = 0; i < NB; i++) begin
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) begin
                            src_done_i[i] = 1'b1;
                            last_done_cyc = cyc;
                        end
                    end
                end
                if (src_req_start_o == 2'b11) begin
                    cnt[0] = dly0;
                    cnt[1] = dly1;
                end
            end
            if (cyc == inject_cyc) src_done_i = src_done_i | 2'b01;
            src_ready_start_i = (cyc >= ready_low_until) ? 2'b11 : 2'b01;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a burst or a completion.
    always @(negedge clk) begin : monitor
        issue_t e;
        job_t   j;
        pc_t    p;
        if (!rst_i) begin
            if (src_req_start_o != '0) begin
                n_cmp++;
                if (issue_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_issue cyc=%0d: got req=%b a0=%h a1=%h size=%0d, none expected",
                             cyc, src_req_start_o, src_base_addr_o[0], src_base_addr_o[1], src_trans_size_o);
                end else begin
                    e = issue_q.pop_front();
                    if (src_req_start_o != 2'b11 || src_base_addr_o[0] != e.a0 ||
                        src_base_addr_o[1] != e.a1 || src_trans_size_o != e.size) begin
                        n_bad++;
                        $display("FAIL issue cyc=%0d: got req=%b a0=%h a1=%h size=%0d, want req=11 a0=%h a1=%h size=%0d",
                                 cyc, src_req_start_o, src_base_addr_o[0], src_base_addr_o[1],
                                 src_trans_size_o, e.a0, e.a1, e.size);
                    end
                end
            end
            if (done_o) begin
                n_cmp++;
                if (done_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_done cyc=%0d: got done_o=1 cnt=%0d, none expected", cyc, chunk_cnt_o);
                end else begin
                    j = done_q.pop_front();
                    if (chunk_cnt_o != LW'(j.cnt) || err_o != 1'b0 ||
                        (j.chk_lat && cyc != last_done_cyc + 1)) begin
                        n_bad++;
                        $display("FAIL job_done cyc=%0d: got cnt=%0d err=%b last_src_done=%0d, want cnt=%0d err=0 done at last_src_done+1",
                                 cyc, chunk_cnt_o, err_o, last_done_cyc, j.cnt);
                    end
                end
            end
        end
        while (pc_q.size() > 0 && pc_q[0].cyc <= cyc) begin
            p = pc_q.pop_front();
            n_cmp++;
            if (p.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s: check for cycle %0d missed at cycle %0d", p.name, p.cyc, cyc);
            end else if (probe(p.kind) != p.val) begin
                n_bad++;
                $display("FAIL %s cyc=%0d: got %0h, want %0h", p.name, cyc, probe(p.kind), p.val);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 3000) begin step(); n++; end
        if (busy_o) push_pc(cyc, K_BUSY, 32'd0, "idle_timeout");
    endtask

    // Issue a start and queue everything the specification predicts for this job.
    task automatic start_job(input int len, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                             input int d0, input int d1, input int rdy_low);
        int     k, off, first;
        issue_t e;
        job_t   j;
        wait_idle();
        dly0 = d0; dly1 = d1;
        k = cyc;
        ready_low_until = k + 1 + rdy_low;
        start_i = 1'b1; total_len_i = LW'(len);
        base_addr_i[0] = b0; base_addr_i[1] = b1;
        off = 0;
        while (off < len) begin
            e.size = LW'((len - off < MB) ? len - off : MB);
            e.a0 = b0 + AW'(off * 4);
            e.a1 = b1 + AW'(off * 4);
            issue_q.push_back(e);
            off += int'(e.size);
        end
        j.cnt = (len + MB - 1) / MB;
        j.chk_lat = (len > 0);
        done_q.push_back(j);
        push_pc(k + 1, K_BUSY, 32'd1, "busy_after_start");
        push_pc(k + 1, K_ERR, 32'd0, "err_cleared_by_start");
        if (len == 0) begin
            push_pc(k + 1, K_DONE, 32'd1, "zero_len_done");
            push_pc(k + 2, K_BUSY, 32'd0, "zero_len_idle");
        end else begin
            first = ((k + 1 > ready_low_until) ? k + 1 : ready_low_until) + 1;
            push_pc(first - 1, K_REQ, 32'd0, "req_before_ready");
            push_pc(first, K_REQ, 32'd3, "req_after_ready");
        end
        step();
        start_i = 1'b0;
        total_len_i = LW'($urandom);
        base_addr_i[0] = AW'($urandom);
        base_addr_i[1] = AW'($urandom);
    endtask

    task automatic finish_job(input int poke);
        int n = 0;
        while (!done_o && n < 3000) begin
            if (n == poke) begin
                start_i = 1'b1; total_len_i = 16'd5;
                base_addr_i[0] = 32'hdead_0000; base_addr_i[1] = 32'hbeef_0000;
            end else begin
                start_i = 1'b0;
            end
            step();
            n++;
        end
        start_i = 1'b0;
        if (!done_o) push_pc(cyc, K_DONE, 32'd1, "job_timeout");
    endtask

    task automatic run_job(input int len, input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                           input int d0, input int d1, input int rdy_low, input int poke);
        start_job(len, b0, b1, d0, d1, rdy_low);
        finish_job(poke);
    endtask

    initial begin : stimulus
        int nreq, n;
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        total_len_i = '0; base_addr_i = '0;
        repeat (3) step();
        rst_i = 1'b0;
        push_pc(cyc, K_ALLZERO, 32'd0, "reset_state");
        step();

        // Three bursts 16/16/8, sources done 3 cycles after each start.
        run_job(40, 32'h0000_1000, 32'h0000_2000, 3, 3, 0, -1);
        // Zero-length job completes without any burst.
        run_job(0, 32'h0000_3000, 32'h0000_4000, 3, 3, 0, -1);
        // Skewed dones: completion follows the later operand.
        run_job(8, 32'h0000_5000, 32'h0000_6000, 2, 6, 0, -1);
        // One source not ready for 4 cycles after start.
        run_job(20, 32'h0000_7000, 32'h0000_8000, 3, 2, 4, -1);

        // Done while idle raises the sticky error; a start while busy is ignored; next start clears err.
        wait_idle();
        step();
        inject_cyc = cyc + 1;
        push_pc(cyc + 2, K_ERR, 32'd1, "err_done_in_idle");
        push_pc(cyc + 4, K_ERR, 32'd1, "err_sticky");
        repeat (5) step();
        run_job(40, 32'h0001_0000, 32'h0002_0000, 2, 4, 0, 6);

        // Clear during the second burst of a 40-word job.
        start_job(40, 32'h0003_0000, 32'h0004_0000, 5, 5, 0);
        nreq = 0; n = 0;
        while (nreq < 2 && n < 500) begin
            if (src_req_start_o != '0) nreq++;
            if (nreq < 2) step();
            n++;
        end
        if (nreq < 2) push_pc(cyc, K_REQ, 32'd3, "second_issue_timeout");
        repeat (2) step();
        clear_i = 1'b1;
        issue_q.delete();
        done_q.delete();
        push_pc(cyc + 1, K_ALLZERO, 32'd0, "clear_all_zero");
        step();
        clear_i = 1'b0;
        repeat (6) step();
        run_job(16, 32'h0005_0000, 32'h0006_0000, 1, 3, 0, -1);

        // Randomised jobs, including one whose addresses wrap past 2^32.
        for (int t = 0; t < 10; t++) begin
            logic [AW-1:0] b0, b1;
            b0 = (t == 3) ? 32'hffff_ffc0 : AW'($urandom);
            b1 = AW'($urandom);
            run_job($urandom_range(1, 70), b0, b1, $urandom_range(1, 6), $urandom_range(1, 6),
                    $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? 3 : -1);
        end

        wait_idle();
        push_pc(cyc + 2, K_QEMPTY, 32'd0, "queues_drained");
        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vfpu_source_ctrl.md
Name: vfpu_source_ctrl

Overview:
Sequencer for the per-operand TCDM-to-stream sources of the vector FPU. It accepts one job (per-operand base address, total vector length), splits it into chunks of at most MAX_BURST words, and issues lock-step start requests to all NB_OPERANDS sources. Before advancing, it waits for every source to report done for the current chunk. It sits between the HWPE control slave (job registers) and the source streamer's control/flag ports. The top level packs its outputs into ctrl_sourcesink_t and unpacks flags_sourcesink_t.

Parameters:
NB_OPERANDS, 2, number of source streams sequenced in lock-step
DATA_WIDTH, 32, stream word width in bits; byte address step per word = DATA_WIDTH/8
ADDR_WIDTH, 32, byte address width
LEN_WIDTH, 16, width of length and size fields (words)
MAX_BURST, 16, maximum words per chunk; must be >=1 and <2^LEN_WIDTH

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear, same effect as rst_i
start_i  in  1  job start request
base_addr_i  in  NB_OPERANDS x ADDR_WIDTH  per-operand byte base address
total_len_i  in  LEN_WIDTH  job length in words
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle job-complete pulse
err_o  out  1  sticky protocol error flag
chunk_cnt_o  out  LEN_WIDTH  chunks completed in the current/last job
src_req_start_o  out  NB_OPERANDS  per-source start pulse
src_base_addr_o  out  NB_OPERANDS x ADDR_WIDTH  per-source chunk base address
src_trans_size_o  out  LEN_WIDTH  chunk size in words, common to all sources
src_ready_start_i  in  NB_OPERANDS  source ready to accept start
src_done_i  in  NB_OPERANDS  source chunk-done pulse

Behaviour:
- Reset/clear: state IDLE; all outputs 0; internal counters and done_seen vector are 0. rst_i has priority over clear_i, and both have priority over every other input.
- FSM states: IDLE, WAIT_RDY, ISSUE, RUN, DONE.
- IDLE: start_i=1 latches base_addr_i, total_len_i and clears chunk_cnt_o and err_o.
  - Next state is WAIT_RDY, or DONE if total_len_i==0.
  - start_i is ignored in every state other than IDLE.
- WAIT_RDY: when all src_ready_start_i bits are 1 in the same cycle, go to ISSUE. Otherwise stay.
- ISSUE: lasts one cycle.
  - src_req_start_o = all ones, registered, so it is high for exactly this cycle.
  - src_trans_size_o = min(remaining, MAX_BURST).
  - src_base_addr_o[i] = current address of operand i.
  - Next state is RUN.
- src_base_addr_o and src_trans_size_o are registered and stay stable from ISSUE until the next ISSUE or IDLE.
- RUN: done_seen[i] |= src_done_i[i].
  - Completion condition: (done_seen | src_done_i) == all ones.
  - On completion: remaining -= chunk; addr[i] += chunk*DATA_WIDTH/8, modulo 2^ADDR_WIDTH; chunk_cnt_o++; done_seen cleared.
  - Next state is DONE if remaining==0, otherwise WAIT_RDY.
- DONE: done_o=1 for this single cycle; next state IDLE. chunk_cnt_o holds its value until the next accepted start.
- Timing:
  - Start sampled at edge k: WAIT_RDY during cycle k+1. If all ready, ISSUE in k+2 and RUN from k+3.
  - Final done sampled at edge m: done_o=1 in cycle m+1, IDLE in m+2.
  - total_len_i==0: done_o in cycle k+1, and src_req_start_o is never asserted.
- err_o is set (sticky) in either case:
  - any src_done_i bit is 1 outside RUN;
  - in RUN, src_done_i[i]=1 while done_seen[i] is already 1.
  The error is otherwise ignored; the sequence continues.
- Clear or reset mid-job: IDLE on the next cycle, with no done_o and no further src_req_start_o.

Decomposition:
- Package vfpu_ctrl_package holds:
  - the FSM state enum (vfpu_src_state_t);
  - the constant BYTES_PER_WORD = DATA_WIDTH/8;
  - the helper function for min(remaining, MAX_BURST).
- Sub-module vfpu_done_collector: per-operand sticky done vector with all-done and duplicate-error outputs, cleared on chunk completion.

Test Plan:
- NB_OPERANDS=2, MAX_BURST=16, len=40, bases 0x1000/0x2000, sources ready and done 3 cycles after each start -> three ISSUE pulses with sizes 16, 16, 8. Op0 bases 0x1000, 0x1040, 0x1080; op1 bases 0x2000, 0x2040, 0x2080. One done_o; chunk_cnt_o=3; err_o=0.
- len=0, start in cycle 0 -> done_o=1 in cycle 1, busy_o=1 only in cycle 1, src_req_start_o never asserted.
- len=8, op0 done 2 cycles and op1 done 6 cycles after ISSUE -> done_o exactly 1 cycle after op1 done; no early advance.
- src_ready_start_i[1] low for 4 cycles after start -> src_req_start_o=2'b11 in a single cycle, 1 cycle after ready_start becomes 2'b11.
- clear_i asserted during RUN of chunk 2 of len=40 -> IDLE next cycle, all outputs 0, no done_o. A new start with len=16 then completes normally with chunk_cnt_o=1.
- src_done_i=2'b01 while IDLE -> err_o=1. start_i while busy -> ignored, latched config unchanged. The next accepted start clears err_o.
